// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART: parity modes,
// FSM state encodings and the oversampling constants.
package uart_pkg;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned START_MID  = 7;

  typedef enum logic [1:0] {NONE, EVEN, ODD} parity_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  // 2'b11 is treated as "no parity", same as 2'b00.
  function automatic parity_t decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return EVEN;
      2'b10:   return ODD;
      default: return NONE;
    endcase
  endfunction
endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO with registered full/empty flags.
// r_data reads as zero while the FIFO is empty.
module uart_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  empty_q, empty_d, full_q, full_d;
  logic                  wr_en, rd_en;

  always_comb begin
    rd_en  = rd && !empty_q;
    // A write to a full FIFO is accepted only when a read frees the slot.
    wr_en  = wr && (!full_q || rd);
    wptr_d = wr_en ? wptr_q + ADDR_WIDTH'(1) : wptr_q;
    rptr_d = rd_en ? rptr_q + ADDR_WIDTH'(1) : rptr_q;
    cnt_d  = cnt_q;
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    empty_d = (cnt_d == '0);
    full_d  = cnt_d[CW-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q] <= w_data;
  end

  assign r_data = empty_q ? '0 : mem[rptr_q];
  assign empty  = empty_q;
  assign full   = full_q;
endmodule

// File: rtl/uart_param.sv
// Full-duplex UART with runtime baud divisor, parity, 1/2 stop bits,
// FIFO status per direction and sticky receive error flags.
module uart_param
  import uart_pkg::*;
#(
  parameter int unsigned DBIT   = 8,
  parameter int unsigned FIFO_W = 4,
  parameter int unsigned DIV_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] divisor,
  input  logic [1:0]       parity_mode,
  input  logic             two_stop,
  input  logic             rx,
  output logic             tx,
  input  logic             rd_uart,
  input  logic             wr_uart,
  input  logic [DBIT-1:0]  w_data,
  output logic [DBIT-1:0]  r_data,
  output logic             rx_empty,
  output logic             rx_full,
  output logic             tx_empty,
  output logic             tx_full,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun_err,
  input  logic             clr_err
);
  localparam int unsigned NW = $clog2(DBIT);
  localparam logic [NW-1:0] N_LAST   = NW'(DBIT - 1);
  localparam logic [3:0]    RS_MID   = 4'(START_MID);
  localparam logic [3:0]    RS_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [4:0]    TS_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]    TS_LAST2 = 5'(2 * OVERSAMPLE - 1);

  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [2:0]       rx_sync_q, rx_sync_d;
  logic             rx_bit, rx_fall;

  rx_state_t        rx_state_q, rx_state_d;
  logic [3:0]       rx_s_q, rx_s_d;
  logic [NW-1:0]    rx_n_q, rx_n_d;
  logic [DBIT-1:0]  rx_sreg_q, rx_sreg_d;
  parity_t          rx_par_q, rx_par_d;
  logic             rx_perr_q, rx_perr_d, rx_push, rx_wr;
  logic             perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;

  tx_state_t        tx_state_q, tx_state_d;
  logic [4:0]       tx_s_q, tx_s_d;
  logic [NW-1:0]    tx_n_q, tx_n_d;
  logic [DBIT-1:0]  tx_sreg_q, tx_sreg_d, tx_head;
  logic             tx_pbit_q, tx_pbit_d, tx_par_en_q, tx_par_en_d;
  logic             tx_two_q, tx_two_d, tx_q, tx_d, tx_load;

  // Tick generator; >= lets a shrinking divisor take effect at the next compare.
  always_comb begin
    tick       = (tick_cnt_q >= divisor);
    tick_cnt_d = tick ? '0 : tick_cnt_q + DIV_W'(1);
    rx_sync_d  = {rx_sync_q[1:0], rx};
  end

  assign rx_bit  = rx_sync_q[1];
  assign rx_fall = rx_sync_q[2] && !rx_sync_q[1];

  always_comb begin
    rx_state_d = rx_state_q;
    rx_s_d     = rx_s_q;
    rx_n_d     = rx_n_q;
    rx_sreg_d  = rx_sreg_q;
    rx_par_d   = rx_par_q;
    rx_perr_d  = rx_perr_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_fall) begin
        rx_state_d = RX_START;
        rx_s_d     = '0;
        rx_par_d   = decode_parity(parity_mode);
        rx_perr_d  = 1'b0;
      end
      RX_START: if (tick) begin
        if (rx_s_q == RS_MID) begin
          rx_state_d = rx_bit ? RX_IDLE : RX_DATA;
          rx_s_d     = '0;
          rx_n_d     = '0;
        end else rx_s_d = rx_s_q + 4'd1;
      end
      RX_DATA: if (tick) begin
        if (rx_s_q == RS_LAST) begin
          rx_s_d    = '0;
          rx_sreg_d = {rx_bit, rx_sreg_q[DBIT-1:1]};
          if (rx_n_q == N_LAST) rx_state_d = (rx_par_q == NONE) ? RX_STOP : RX_PARITY;
          else rx_n_d = rx_n_q + NW'(1);
        end else rx_s_d = rx_s_q + 4'd1;
      end
      RX_PARITY: if (tick) begin
        if (rx_s_q == RS_LAST) begin
          rx_s_d     = '0;
          rx_perr_d  = rx_bit != (^rx_sreg_q ^ (rx_par_q == ODD));
          rx_state_d = RX_STOP;
        end else rx_s_d = rx_s_q + 4'd1;
      end
      RX_STOP: if (tick) begin
        if (rx_s_q == RS_LAST) begin
          rx_push    = 1'b1;
          rx_state_d = RX_IDLE;
        end else rx_s_d = rx_s_q + 4'd1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
    rx_wr  = rx_push && !rx_full;
    perr_d = (rx_push && rx_perr_q) || (perr_q && !clr_err);
    ferr_d = (rx_push && !rx_bit) || (ferr_q && !clr_err);
    ovr_d  = (rx_push && rx_full) || (ovr_q && !clr_err);
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_s_d      = tx_s_q;
    tx_n_d      = tx_n_q;
    tx_sreg_d   = tx_sreg_q;
    tx_pbit_d   = tx_pbit_q;
    tx_par_en_d = tx_par_en_q;
    tx_two_d    = tx_two_q;
    tx_load     = 1'b0;
    case (tx_state_q)
      TX_IDLE: tx_load = tick && !tx_empty;
      TX_START: if (tick) begin
        if (tx_s_q == TS_LAST) begin
          tx_s_d     = '0;
          tx_n_d     = '0;
          tx_state_d = TX_DATA;
        end else tx_s_d = tx_s_q + 5'd1;
      end
      TX_DATA: if (tick) begin
        if (tx_s_q == TS_LAST) begin
          tx_s_d    = '0;
          tx_sreg_d = {1'b0, tx_sreg_q[DBIT-1:1]};
          if (tx_n_q == N_LAST) tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP;
          else tx_n_d = tx_n_q + NW'(1);
        end else tx_s_d = tx_s_q + 5'd1;
      end
      TX_PARITY: if (tick) begin
        if (tx_s_q == TS_LAST) begin
          tx_s_d     = '0;
          tx_state_d = TX_STOP;
        end else tx_s_d = tx_s_q + 5'd1;
      end
      TX_STOP: if (tick) begin
        if (tx_s_q == (tx_two_q ? TS_LAST2 : TS_LAST)) begin
          tx_state_d = TX_IDLE;
          tx_load    = !tx_empty;
        end else tx_s_d = tx_s_q + 5'd1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Loading from IDLE or straight out of STOP gives back-to-back frames.
    if (tx_load) begin
      tx_state_d  = TX_START;
      tx_s_d      = '0;
      tx_sreg_d   = tx_head;
      tx_par_en_d = (decode_parity(parity_mode) != NONE);
      tx_pbit_d   = ^tx_head ^ (decode_parity(parity_mode) == ODD);
      tx_two_d    = two_stop;
    end
    case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_sreg_d[0];
      TX_PARITY: tx_d = tx_pbit_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q  <= '0;
      rx_sync_q   <= '1;
      rx_state_q  <= RX_IDLE;
      rx_s_q      <= '0;
      rx_n_q      <= '0;
      rx_sreg_q   <= '0;
      rx_par_q    <= NONE;
      rx_perr_q   <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_s_q      <= '0;
      tx_n_q      <= '0;
      tx_sreg_q   <= '0;
      tx_pbit_q   <= 1'b0;
      tx_par_en_q <= 1'b0;
      tx_two_q    <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      rx_sync_q   <= rx_sync_d;
      rx_state_q  <= rx_state_d;
      rx_s_q      <= rx_s_d;
      rx_n_q      <= rx_n_d;
      rx_sreg_q   <= rx_sreg_d;
      rx_par_q    <= rx_par_d;
      rx_perr_q   <= rx_perr_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
      tx_state_q  <= tx_state_d;
      tx_s_q      <= tx_s_d;
      tx_n_q      <= tx_n_d;
      tx_sreg_q   <= tx_sreg_d;
      tx_pbit_q   <= tx_pbit_d;
      tx_par_en_q <= tx_par_en_d;
      tx_two_q    <= tx_two_d;
      tx_q        <= tx_d;
    end
  end

  uart_fifo #(.DATA_WIDTH(DBIT), .ADDR_WIDTH(FIFO_W)) u_rx_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .rd     (rd_uart),
    .wr     (rx_wr),
    .w_data (rx_sreg_q),
    .r_data (r_data),
    .empty  (rx_empty),
    .full   (rx_full)
  );

  uart_fifo #(.DATA_WIDTH(DBIT), .ADDR_WIDTH(FIFO_W)) u_tx_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .rd     (tx_load),
    .wr     (wr_uart),
    .w_data (w_data),
    .r_data (tx_head),
    .empty  (tx_empty),
    .full   (tx_full)
  );

  assign tx          = tx_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;
endmodule

// File: tb/tb_uart_param.sv
// Self-checking bench for uart_param: table-driven TX frames, loopback,
// injected RX error frames, overrun, glitch, reset and randomized frames.
`timescale 1ns/1ps
module tb_uart_param;
  localparam int unsigned DBIT   = 8;
  localparam int unsigned FIFO_W = 2;
  localparam int unsigned DIV_W  = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [DIV_W-1:0] divisor = 16'd3;
  logic [1:0]       parity_mode = 2'b00;
  logic             two_stop = 1'b0;
  logic             rx, tx;
  logic             rx_drv = 1'b1, loop_en = 1'b0;
  logic             rd_uart = 1'b0, wr_uart = 1'b0, clr_err = 1'b0;
  logic [DBIT-1:0]  w_data = '0, r_data;
  logic             rx_empty, rx_full, tx_empty, tx_full;
  logic             parity_err, frame_err, overrun_err;
  int               cyc = 0;
  int               n_checks = 0, n_fail = 0;

  assign rx = loop_en ? tx : rx_drv;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_param #(.DBIT(DBIT), .FIFO_W(FIFO_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset_n(reset_n), .divisor(divisor), .parity_mode(parity_mode),
    .two_stop(two_stop), .rx(rx), .tx(tx), .rd_uart(rd_uart), .wr_uart(wr_uart),
    .w_data(w_data), .r_data(r_data), .rx_empty(rx_empty), .rx_full(rx_full),
    .tx_empty(tx_empty), .tx_full(tx_full), .parity_err(parity_err),
    .frame_err(frame_err), .overrun_err(overrun_err), .clr_err(clr_err)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic       two;
    int         len;
    logic       pbit;
  } tx_vec_t;
  tx_vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int bit_time();
    return 16 * (int'(divisor) + 1);
  endfunction

  function automatic logic has_par(input logic [1:0] mode);
    return (mode == 2'b01) || (mode == 2'b10);
  endfunction

  // Reference frame: bit i of the result is the i-th line bit in time order.
  function automatic logic [15:0] model_frame(input logic [7:0] d, input logic [1:0] mode);
    logic [15:0] b = '1;
    b[0]   = 1'b0;
    b[8:1] = d;
    if (mode == 2'b01) b[9] = ($countones(d) % 2) == 1;
    if (mode == 2'b10) b[9] = ($countones(d) % 2) == 0;
    return b;
  endfunction

  function automatic int model_len(input logic [1:0] mode, input logic two);
    return 10 + (has_par(mode) ? 1 : 0) + (two ? 1 : 0);
  endfunction

  function automatic logic [15:0] table_bits(input tx_vec_t v);
    logic [15:0] b = '1;
    b[0]   = 1'b0;
    b[8:1] = v.data;
    if (has_par(v.mode)) b[9] = v.pbit;
    return b;
  endfunction

  task automatic push_tx(input logic [7:0] d);
    w_data = d; wr_uart = 1'b1;
    @(negedge clk);
    wr_uart = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic pop_rx();
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
  endtask

  task automatic wait_tx_fall(input int bound, output int k);
    k = 0;
    while (tx !== 1'b0 && k < bound) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Called at the negedge where the start bit was first seen.
  task automatic sample_tx(input string name, input logic [15:0] bits, input int len,
                           input int nfr);
    int bt = bit_time();
    repeat (bt / 2) @(negedge clk);
    for (int i = 0; i < nfr * len; i++) begin
      check($sformatf("%s_bit%0d", name, i), 32'(tx), 32'(bits[i % len]));
      repeat (bt) @(negedge clk);
    end
    check({name, "_idle"}, 32'(tx), 32'd1);
    check({name, "_txempty"}, 32'(tx_empty), 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic [1:0] mode, input logic flip,
                         input logic stop0);
    logic [15:0] b = model_frame(d, mode);
    int len = model_len(mode, 1'b0);
    int bt = bit_time();
    if (flip && has_par(mode)) b[9] = ~b[9];
    if (stop0) b[len-1] = 1'b0;
    for (int i = 0; i < len; i++) begin
      rx_drv = b[i];
      repeat (bt) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (2 * bt) @(negedge clk);
  endtask

  task automatic expect_rx(input string name, input logic [7:0] d, input logic pe,
                           input logic fe, input int bound, output int t_seen);
    int k = 0;
    while (rx_empty && k < bound) begin
      @(negedge clk);
      k++;
    end
    t_seen = cyc;
    check({name, "_avail"}, 32'(rx_empty), 32'd0);
    check({name, "_data"}, 32'(r_data), 32'(d));
    check({name, "_perr"}, 32'(parity_err), 32'(pe));
    check({name, "_ferr"}, 32'(frame_err), 32'(fe));
    pop_rx();
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, t1, t2, t3;
    logic [7:0] d;
    logic [1:0] m;
    logic tw, fl, s0;
    int bt;

    vecs[0] = '{8'hA5, 2'b00, 1'b0, 10, 1'b0};
    vecs[1] = '{8'hA5, 2'b01, 1'b0, 11, 1'b0};
    vecs[2] = '{8'hA5, 2'b10, 1'b1, 12, 1'b1};
    vecs[3] = '{8'h00, 2'b01, 1'b1, 12, 1'b0};
    vecs[4] = '{8'hFF, 2'b10, 1'b0, 11, 1'b1};
    vecs[5] = '{8'h3C, 2'b11, 1'b1, 11, 1'b0};
    vecs[6] = '{8'h07, 2'b01, 1'b0, 11, 1'b1};
    vecs[7] = '{8'h5B, 2'b10, 1'b1, 12, 1'b0};

    // Reset values
    #12;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_tx_empty", 32'(tx_empty), 32'd1);
    check("rst_full", 32'({rx_full, tx_full}), 32'd0);
    check("rst_r_data", 32'(r_data), 32'd0);
    check("rst_errs", 32'({parity_err, frame_err, overrun_err}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xA5 8N1 at divisor 3: latency, tx_empty after pop, bit pattern
    push_tx(8'hA5);
    wait_tx_fall(int'(divisor) + 3, k);
    check("a5_latency", 32'(tx == 1'b0 && k <= int'(divisor) + 3), 32'd1);
    check("a5_txempty_after_pop", 32'(tx_empty), 32'd1);
    sample_tx("a5", 16'hFF4A, 10, 1);

    // Table: two back-to-back frames per vector
    foreach (vecs[v]) begin
      parity_mode = vecs[v].mode;
      two_stop    = vecs[v].two;
      push_tx(vecs[v].data);
      push_tx(vecs[v].data);
      wait_tx_fall(int'(divisor) + 6, k);
      check($sformatf("tbl%0d_start", v), 32'(tx), 32'd0);
      sample_tx($sformatf("tbl%0d", v), table_bits(vecs[v]), vecs[v].len, 2);
    end

    // Loopback, even parity, two stop bits
    parity_mode = 2'b01; two_stop = 1'b1; loop_en = 1'b1;
    bt = bit_time();
    push_tx(8'h00); push_tx(8'hFF); push_tx(8'h3C);
    expect_rx("lb0", 8'h00, 1'b0, 1'b0, 20 * bt, t1);
    expect_rx("lb1", 8'hFF, 1'b0, 1'b0, 20 * bt, t2);
    expect_rx("lb2", 8'h3C, 1'b0, 1'b0, 20 * bt, t3);
    check("lb_len01", 32'((t2 - t1) >= 12 * bt - 2 && (t2 - t1) <= 12 * bt + 2), 32'd1);
    check("lb_len12", 32'((t3 - t2) >= 12 * bt - 2 && (t3 - t2) <= 12 * bt + 2), 32'd1);
    repeat (2 * bt) @(negedge clk);
    loop_en = 1'b0; two_stop = 1'b0;

    // Parity error then framing error; both bytes kept
    send_rx(8'h13, 2'b01, 1'b1, 1'b0);
    check("perr_set", 32'({parity_err, frame_err}), 32'b10);
    send_rx(8'h81, 2'b01, 1'b0, 1'b1);
    check("ferr_set", 32'({parity_err, frame_err}), 32'b11);
    check("err_byte0", 32'(r_data), 32'h13);
    pop_rx();
    check("err_byte1", 32'(r_data), 32'h81);
    pop_rx();
    check("err_rx_empty", 32'(rx_empty), 32'd1);
    pulse_clr();
    check("err_cleared", 32'({parity_err, frame_err, overrun_err}), 32'd0);

    // Overrun with a 4-deep RX FIFO
    parity_mode = 2'b00;
    for (int i = 0; i < 5; i++) begin
      send_rx(8'(8'h11 * (i + 1)), 2'b00, 1'b0, 1'b0);
      if (i == 3) check("ovr_full_at4", 32'({rx_full, overrun_err}), 32'b10);
    end
    check("ovr_flag", 32'({rx_full, overrun_err}), 32'b11);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovr_byte%0d", i), 32'(r_data), 32'(8'(8'h11 * (i + 1))));
      pop_rx();
    end
    check("ovr_drained", 32'(rx_empty), 32'd1);
    pulse_clr();

    // Three-tick low glitch is rejected
    rx_drv = 1'b0;
    repeat (3 * (int'(divisor) + 1)) @(negedge clk);
    rx_drv = 1'b1;
    repeat (12 * bit_time()) @(negedge clk);
    check("glitch_rx_empty", 32'(rx_empty), 32'd1);
    check("glitch_ferr", 32'(frame_err), 32'd0);

    // Randomized injected frames against the reference model
    for (int i = 0; i < 8; i++) begin
      divisor = 16'($urandom_range(0, 3));
      d = 8'($urandom);
      m = 2'($urandom_range(0, 3));
      fl = ($urandom_range(0, 3) == 0);
      s0 = ($urandom_range(0, 3) == 0);
      parity_mode = m;
      pulse_clr();
      send_rx(d, m, fl, s0);
      expect_rx($sformatf("rnd%0d", i), d, fl && has_par(m), s0, 4 * bit_time(), t1);
    end

    // Randomized loopback frames
    pulse_clr();
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      divisor = 16'($urandom_range(0, 3));
      d = 8'($urandom);
      m = 2'($urandom_range(0, 3));
      tw = 1'($urandom_range(0, 1));
      parity_mode = m; two_stop = tw;
      push_tx(d);
      expect_rx($sformatf("rlb%0d", i), d, 1'b0, 1'b0,
                (model_len(m, tw) + 4) * bit_time(), t1);
      repeat (3 * bit_time()) @(negedge clk);
    end
    loop_en = 1'b0; two_stop = 1'b0; parity_mode = 2'b00; divisor = 16'd3;
    repeat (2 * bit_time()) @(negedge clk);

    // Reset in the middle of a TX frame with a second byte queued
    push_tx(8'h96); push_tx(8'h69);
    wait_tx_fall(int'(divisor) + 6, k);
    repeat (3 * bit_time()) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_tx_empty", 32'(tx_empty), 32'd1);
    check("mid_rst_errs", 32'({parity_err, frame_err, overrun_err}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3 * bit_time()) @(negedge clk);
    check("post_rst_idle", 32'({tx, tx_empty}), 32'b11);
    push_tx(8'h3C);
    wait_tx_fall(int'(divisor) + 3, k);
    check("post_rst_latency", 32'(tx == 1'b0 && k <= int'(divisor) + 3), 32'd1);
    sample_tx("post_rst", model_frame(8'h3C, 2'b00), model_len(2'b00, 1'b0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_param.md
# uart_param

Parametrised full-duplex UART that supersedes the fixed 8N1 UART top level. It adds a runtime baud divisor, configurable parity and stop bits, per-direction FIFO status, and sticky receive error flags. It sits between the pin pair (rx/tx) and the user or processor interface. The oversampling receiver and shift-register transmitter are built in; only the two FIFOs are separate instances.

## Interface
- DBIT, 8: data bits per frame, legal range 5..8; `w_data`/`r_data` width.
- FIFO_W, 4: FIFO address width; depth = 2^FIFO_W per direction.
- DIV_W, 16: width of the baud divisor.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- divisor  in  DIV_W  oversample tick every divisor+1 clk cycles.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none.
- two_stop  in  1  TX sends 2 stop bits when 1.
- rx  in  1  serial input, asynchronous to clk.
- tx  out  1  serial output, idle high.
- rd_uart  in  1  pop RX FIFO.
- wr_uart  in  1  push `w_data` into TX FIFO.
- w_data  in  DBIT  TX data.
- r_data  out  DBIT  RX FIFO head (first-word-fall-through).
- rx_empty / rx_full / tx_empty / tx_full  out  1  FIFO status.
- parity_err / frame_err / overrun_err  out  1  sticky error flags.
- clr_err  in  1  clear all three error flags.

## Operation
- Tick generator: counter runs 0..divisor, pulses `tick` for 1 clk at divisor, then restarts at 0. divisor=0 gives a tick every clk. A divisor change takes effect at the next counter compare.
- Both FSMs latch `parity_mode`/`two_stop` at frame start. Mid-frame changes affect only the next frame.
- `rx` passes through a 2-FF synchroniser before any use.
- RX FSM states: IDLE → START → DATA → PARITY (skipped if no parity) → STOP → IDLE.
  - IDLE→START on a synchronised 1→0 edge.
  - START: at tick 7, if rx=1 it is a glitch → IDLE; otherwise reset the tick count.
  - DATA: sample every 16 ticks, DBIT bits, LSB first.
  - PARITY: sample and compare.
  - STOP: sample one stop bit after 16 ticks, regardless of `two_stop`.
- RX push: at the stop sample, the byte is pushed even with errors. A parity mismatch sets `parity_err`; stop=0 sets `frame_err`.
- RX overrun: if the RX FIFO is full at push, the byte is dropped and `overrun_err` is set.
- TX FSM states: IDLE → START → DATA → PARITY (optional) → STOP → IDLE.
  - In IDLE with the TX FIFO non-empty: pop the head into the shift register in the same cycle and enter START.
  - Each bit lasts 16 ticks. STOP lasts 16 ticks, or 32 if `two_stop`.
  - Back-to-back frames: STOP→START directly when the FIFO is non-empty (no idle bit).
- Parity: even → parity bit = XOR of the data bits; odd → its inverse.
- FIFOs:
  - `wr` when full: ignored. `rd` when empty: ignored.
  - Simultaneous rd+wr when full: both occur, count unchanged.
  - Simultaneous rd+wr when empty: write only.
  - Pointers wrap modulo 2^FIFO_W. A full/empty distinction is required at every depth.
- Error flags: set and `clr_err` in the same cycle → set wins.
- Reset values (async reset_n=0, all outputs):
  - tx=1; rx_empty=1, tx_empty=1, rx_full=0, tx_full=0.
  - r_data=0; all error flags 0.
  - Both FSMs in IDLE; tick counter 0.
  - Any frame in flight is abandoned. FIFO contents are discarded.

## Timing
- Bit time = 16·(divisor+1) clk.
- wr_uart into an empty idle TX: `tx` falls within divisor+3 clk; the FSM starts on the next tick.
- RX: `rx_empty` deasserts and `r_data` is valid 1 clk after the STOP sample tick.
- Status flags are registered and update 1 clk after the causing `rd`/`wr`/push/pop.
- RX input-to-sample latency includes the 2-cycle synchroniser delay.

## Structure
- Package `uart_pkg` holds:
  - `parity_t` enum (NONE, EVEN, ODD);
  - `rx_state_t` and `tx_state_t` enums;
  - localparam `OVERSAMPLE = 16` and `START_MID = 7`.
- Sub-module `uart_fifo` (DATA_WIDTH, ADDR_WIDTH; first-word-fall-through) is instantiated twice.
- The tick generator and both FSMs live in `uart_param`.

## Test plan
- divisor=3, 8N1, wr 0xA5: tx shows start, bits 1,0,1,0,0,1,0,1 LSB-first, stop; each bit 64 clk; tx_empty=1 after the pop.
- Loopback tx→rx, even parity, two_stop=1, bytes 0x00, 0xFF, 0x3C: r_data returns them in order; no error flags; frame length 12 bits.
- Inject an odd-parity frame while configured even; then a frame with stop=0: parity_err=1, then frame_err=1, both bytes present in RX FIFO. clr_err → flags 0.
- FIFO_W=2: send 5 frames without rd_uart → rx_full=1 after 4, overrun_err=1, first 4 bytes intact.
- 3-tick-wide low glitch on rx at divisor=3: no byte received, rx_empty stays 1.
- Assert reset_n low mid-TX-frame: tx=1 immediately, tx_empty=1. After release, the next wr transmits cleanly.
